// File: rtl/clct_peak_hold.sv
// CLCT peak-hold stage: thresholds the sorter's best pattern every bx, keeps the strongest
// candidate over a DRIFT_WIN-bx window, emits it as a 1-clock pulse, then waits DEAD_BX bx.
module clct_peak_hold #(
  parameter int MXPATB    = 7,
  parameter int MXKEYBX   = 8,
  parameter int DRIFT_WIN = 3,
  parameter int DEAD_BX   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pat_en,
  input  logic [2:0]         hit_thresh,
  input  logic [3:0]         pid_thresh,
  input  logic [MXPATB-1:0]  best_pat,
  input  logic [MXKEYBX-1:0] best_key,
  output logic               clct_vld,
  output logic [MXPATB-1:0]  clct_pat,
  output logic [MXKEYBX-1:0] clct_key,
  output logic [2:0]         clct_nbx,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DEAD} state_t;

  localparam logic [2:0] LAST_CNT  = 3'(DRIFT_WIN - 1);
  localparam logic [3:0] DEAD_INIT = 4'((DEAD_BX == 0) ? 0 : DEAD_BX - 1);
  localparam state_t     POST_EMIT = (DEAD_BX == 0) ? IDLE : DEAD;

  state_t               r_state, w_state_nxt;
  logic [MXPATB-1:0]    r_s1_pat, r_hold_pat, w_hold_pat_nxt, w_mrg_pat, w_emit_pat;
  logic [MXKEYBX-1:0]   r_s1_key, r_hold_key, w_hold_key_nxt, w_mrg_key, w_emit_key;
  logic [2:0]           r_hold_nbx, w_hold_nbx_nxt, w_mrg_nbx, w_emit_nbx;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic [3:0]           r_dcnt, w_dcnt_nxt;
  logic                 r_s1_q, w_beats, w_emit;

  // Stage 1: register the sorter output and its qualification
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_s1_pat <= '0;
      r_s1_key <= '0;
      r_s1_q   <= 1'b0;
    end else begin
      r_s1_pat <= best_pat;
      r_s1_key <= best_key;
      r_s1_q   <= pat_en && (best_pat[MXPATB-1 -: 3] >= hit_thresh) &&
                  (best_pat[3:0] >= pid_thresh);
    end
  end

  // Bend bit is excluded so a direction flip never displaces an equal-quality earlier hit
  assign w_beats   = r_s1_q && (r_s1_pat[MXPATB-1:1] > r_hold_pat[MXPATB-1:1]);
  assign w_mrg_pat = w_beats ? r_s1_pat : r_hold_pat;
  assign w_mrg_key = w_beats ? r_s1_key : r_hold_key;
  assign w_mrg_nbx = w_beats ? r_cnt    : r_hold_nbx;

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_pat_nxt = r_hold_pat;
    w_hold_key_nxt = r_hold_key;
    w_hold_nbx_nxt = r_hold_nbx;
    w_cnt_nxt      = r_cnt;
    w_dcnt_nxt     = r_dcnt;
    w_emit         = 1'b0;
    w_emit_pat     = w_mrg_pat;
    w_emit_key     = w_mrg_key;
    w_emit_nbx     = w_mrg_nbx;
    case (r_state)
      IDLE: begin
        if (r_s1_q) begin
          if (DRIFT_WIN == 1) begin
            w_emit      = 1'b1;
            w_emit_pat  = r_s1_pat;
            w_emit_key  = r_s1_key;
            w_emit_nbx  = 3'd0;
            w_state_nxt = POST_EMIT;
            w_dcnt_nxt  = DEAD_INIT;
          end else begin
            w_hold_pat_nxt = r_s1_pat;
            w_hold_key_nxt = r_s1_key;
            w_hold_nbx_nxt = 3'd0;
            w_cnt_nxt      = 3'd1;
            w_state_nxt    = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (r_cnt == LAST_CNT) begin
          w_emit      = 1'b1;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = POST_EMIT;
          w_dcnt_nxt  = DEAD_INIT;
        end else begin
          w_hold_pat_nxt = w_mrg_pat;
          w_hold_key_nxt = w_mrg_key;
          w_hold_nbx_nxt = w_mrg_nbx;
          w_cnt_nxt      = r_cnt + 3'd1;
        end
      end
      DEAD: begin
        if (r_dcnt == 4'd0) w_state_nxt = IDLE;
        else                w_dcnt_nxt  = r_dcnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_hold_pat <= '0;
      r_hold_key <= '0;
      r_hold_nbx <= '0;
      r_cnt      <= '0;
      r_dcnt     <= '0;
      clct_vld   <= 1'b0;
      clct_pat   <= '0;
      clct_key   <= '0;
      clct_nbx   <= '0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_pat <= w_hold_pat_nxt;
      r_hold_key <= w_hold_key_nxt;
      r_hold_nbx <= w_hold_nbx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dcnt     <= w_dcnt_nxt;
      clct_vld   <= w_emit;
      busy       <= (w_state_nxt != IDLE);
      // Candidate fields stay put between pulses for the readout side
      if (w_emit) begin
        clct_pat <= w_emit_pat;
        clct_key <= w_emit_key;
        clct_nbx <= w_emit_nbx;
      end
    end
  end

endmodule

// File: tb/tb_clct_peak_hold.sv
// Directed bench for clct_peak_hold: a scoreboard of expected emissions (cycle, pat, key, nbx)
// is filled as stimulus is driven and drained by a negedge monitor on the main instance.
module tb_clct_peak_hold;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pat_en;
  logic [2:0] hit_thresh;
  logic [3:0] pid_thresh;
  logic [6:0] best_pat;
  logic [7:0] best_key;

  logic       vld, busy;
  logic [6:0] pat;
  logic [7:0] key;
  logic [2:0] nbx;
  logic       b_vld, b_busy, c_vld, c_busy;
  logic [6:0] b_pat, c_pat;
  logic [7:0] b_key, c_key;
  logic [2:0] b_nbx, c_nbx;

  int ncmp = 0, nerr = 0, cyc = 0, b_cnt = 0, c_cnt = 0;

  typedef struct {
    int         cyc;
    logic [6:0] pat;
    logic [7:0] key;
    logic [2:0] nbx;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  clct_peak_hold #(.DRIFT_WIN(3), .DEAD_BX(4)) u_dut (
    .clock(clock), .reset_n(reset_n), .pat_en(pat_en), .hit_thresh(hit_thresh),
    .pid_thresh(pid_thresh), .best_pat(best_pat), .best_key(best_key),
    .clct_vld(vld), .clct_pat(pat), .clct_key(key), .clct_nbx(nbx), .busy(busy));

  clct_peak_hold #(.DRIFT_WIN(3), .DEAD_BX(0)) u_b (
    .clock(clock), .reset_n(reset_n), .pat_en(pat_en), .hit_thresh(hit_thresh),
    .pid_thresh(pid_thresh), .best_pat(best_pat), .best_key(best_key),
    .clct_vld(b_vld), .clct_pat(b_pat), .clct_key(b_key), .clct_nbx(b_nbx), .busy(b_busy));

  clct_peak_hold #(.DRIFT_WIN(1), .DEAD_BX(0)) u_c (
    .clock(clock), .reset_n(reset_n), .pat_en(pat_en), .hit_thresh(hit_thresh),
    .pid_thresh(pid_thresh), .best_pat(best_pat), .best_key(best_key),
    .clct_vld(c_vld), .clct_pat(c_pat), .clct_key(c_key), .clct_nbx(c_nbx), .busy(c_busy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bx(input logic [6:0] p, input logic [7:0] k);
    best_pat = p;
    best_key = k;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) bx(7'h00, 8'h00);
  endtask

  // Called just before driving a window's first bx; pulse is seen dly negedges later
  task automatic expect_at(input int dly, input logic [6:0] p, input logic [7:0] k,
                           input logic [2:0] n);
    exp_t e;
    e.cyc = cyc + dly;
    e.pat = p;
    e.key = k;
    e.nbx = n;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (b_vld === 1'b1) b_cnt++;
    if (c_vld === 1'b1) c_cnt++;
    if (vld === 1'b1) begin
      if (sb.size() == 0) chk("unexp_vld", {31'd0, vld}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("vld_cyc", cyc, e.cyc);
        chk("vld_pat", {25'd0, pat}, {25'd0, e.pat});
        chk("vld_key", {24'd0, key}, {24'd0, e.key});
        chk("vld_nbx", {29'd0, nbx}, {29'd0, e.nbx});
      end
    end
  end

  initial begin
    int b0, c0;
    reset_n = 1'b0; pat_en = 1'b1; hit_thresh = 3'd3; pid_thresh = 4'd2;
    best_pat = '0; best_key = '0;
    tick(); tick();
    chk("rst_main", {13'd0, vld, pat, key, nbx, busy}, 32'd0);
    chk("rst_b", {13'd0, b_vld, b_pat, b_key, b_nbx, b_busy}, 32'd0);
    chk("rst_c", {13'd0, c_vld, c_pat, c_key, c_nbx, c_busy}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // T1: single candidate, latency and busy span
    expect_at(4, 7'h52, 8'h25, 3'd0);
    bx(7'h52, 8'h25);
    chk("t1_busy_e0", {31'd0, busy}, 32'd0);
    bx(7'h00, 8'h00);
    chk("t1_busy_e1", {31'd0, busy}, 32'd1);
    idle(3);
    chk("t1_vld_drop", {31'd0, vld}, 32'd0);
    chk("t1_pat_held", {25'd0, pat}, 32'h52);
    chk("t1_key_held", {24'd0, key}, 32'h25);
    idle(2);
    chk("t1_busy_e6", {31'd0, busy}, 32'd1);
    idle(1);
    chk("t1_busy_e7", {31'd0, busy}, 32'd0);
    idle(4);

    // T2: replacement, tie keeps earlier, last-bx replacement
    expect_at(4, 7'h63, 8'hC1, 3'd1);
    bx(7'h42, 8'h10); bx(7'h63, 8'hC1); bx(7'h62, 8'h12);
    idle(10);
    expect_at(4, 7'h42, 8'h20, 3'd0);
    bx(7'h42, 8'h20); bx(7'h43, 8'h21);
    idle(10);
    expect_at(4, 7'h7F, 8'h52, 3'd2);
    bx(7'h42, 8'h50); bx(7'h00, 8'h00); bx(7'h7F, 8'h52);
    idle(10);

    // T3: threshold boundaries
    bx(7'h22, 8'h01);
    bx(7'h31, 8'h02);
    chk("t3_busy_hits", {31'd0, busy}, 32'd0);
    bx(7'h00, 8'h00);
    chk("t3_busy_pid", {31'd0, busy}, 32'd0);
    idle(3);
    expect_at(4, 7'h32, 8'h33, 3'd0);
    bx(7'h32, 8'h33);
    idle(10);

    // T4: continuous qualified stream on all three parameterisations
    b0 = b_cnt; c0 = c_cnt;
    for (int i = 0; i < 21; i++) begin
      if (i % 7 == 0) expect_at(4, 7'h52, 8'(i), 3'd0);
      bx(7'h52, 8'(i));
    end
    idle(12);
    chk("t4_b_pulses", b_cnt - b0, 32'd7);
    chk("t4_c_pulses", c_cnt - c0, 32'd21);

    // T5: reset in the middle of a window
    bx(7'h52, 8'h30);
    bx(7'h00, 8'h00);
    reset_n = 1'b0;
    bx(7'h00, 8'h00);
    chk("t5_rst_outs", {13'd0, vld, pat, key, nbx, busy}, 32'd0);
    reset_n = 1'b1;
    idle(6);
    expect_at(4, 7'h5A, 8'h31, 3'd0);
    bx(7'h5A, 8'h31);
    idle(10);

    // T6: pat_en dropped after the first bx of an open window
    expect_at(4, 7'h54, 8'h40, 3'd0);
    bx(7'h54, 8'h40);
    pat_en = 1'b0;
    for (int i = 0; i < 14; i++) bx(7'h7F, 8'(8'h41 + i));
    chk("t6_busy_off", {31'd0, busy}, 32'd0);
    pat_en = 1'b1;
    idle(4);

    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
